// File: rtl/rr_multi_select_unit_if.sv
// Request/grant bundle for rr_multi_select_unit.
// The master side drives requests and the handshake, and the slave side returns grants.
interface rr_multi_select_unit_if #(
    parameter int REQ_NUM = 8,
    parameter int ACK_SEL = 3,
    parameter int GNT_NUM = 2
);
    logic [REQ_NUM-1:0]         i_req;
    logic                       i_ack_rdy;
    logic                       i_flush;
    logic [GNT_NUM-1:0]         o_ack_vld;
    logic [GNT_NUM*ACK_SEL-1:0] o_ack;
    logic [REQ_NUM-1:0]         o_gnt_mask;
    logic [ACK_SEL-1:0]         o_ptr;

    modport master (
        output i_req, i_ack_rdy, i_flush,
        input  o_ack_vld, o_ack, o_gnt_mask, o_ptr
    );

    modport slave (
        input  i_req, i_ack_rdy, i_flush,
        output o_ack_vld, o_ack, o_gnt_mask, o_ptr
    );
endinterface

// File: rtl/rr_multi_select_unit.sv
// Multi-grant selector that picks up to GNT_NUM requesters in rotating-priority or
// fixed-priority order, with a round-robin pointer that advances on the consumer handshake.
module rr_multi_select_unit #(
    parameter int REQ_NUM = 8,
    parameter int ACK_SEL = 3,
    parameter int GNT_NUM = 2,
    parameter int MODE    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rr_multi_select_unit_if.slave bus
);
    localparam logic [ACK_SEL:0] REQ_LIM = (ACK_SEL+1)'(REQ_NUM);
    localparam int unsigned      GNT_LIM = GNT_NUM;

    logic [ACK_SEL-1:0]         ptr;
    logic [ACK_SEL-1:0]         ptr_nxt;
    logic [ACK_SEL-1:0]         last_idx;
    logic [ACK_SEL:0]           idx_sum;
    logic [ACK_SEL:0]           last_inc;
    logic [2*REQ_NUM-1:0]       req_dbl;
    logic [2*REQ_NUM-1:0]       gnt_dbl;
    logic [REQ_NUM-1:0]         req_rot;
    logic [REQ_NUM-1:0]         gnt_rot;
    logic [GNT_NUM-1:0]         ack_vld;
    logic [GNT_NUM*ACK_SEL-1:0] ack;
    int unsigned                cnt;

    // Rotate requests so that position 0 is the current pointer, then take the
    // first GNT_NUM set bits in ascending rotated order.
    always_comb begin
        req_dbl  = {bus.i_req, bus.i_req} >> ptr;
        req_rot  = req_dbl[REQ_NUM-1:0];
        gnt_rot  = '0;
        ack_vld  = '0;
        ack      = '0;
        last_idx = '0;
        idx_sum  = '0;
        cnt      = 0;
        for (int unsigned o = 0; o < REQ_NUM; o++) begin
            idx_sum = {1'b0, ptr} + (ACK_SEL+1)'(o);
            if (idx_sum >= REQ_LIM) begin
                idx_sum = idx_sum - REQ_LIM;
            end
            if (req_rot[o] && (cnt < GNT_LIM)) begin
                gnt_rot[o] = 1'b1;
                for (int unsigned k = 0; k < GNT_NUM; k++) begin
                    if (k == cnt) begin
                        ack_vld[k]                 = 1'b1;
                        ack[k*ACK_SEL +: ACK_SEL]  = idx_sum[ACK_SEL-1:0];
                    end
                end
                last_idx = idx_sum[ACK_SEL-1:0];
                cnt      = cnt + 1;
            end
        end
    end

    // Rotate the grant mask back into absolute requester positions.
    always_comb begin
        gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    end

    always_comb begin
        last_inc = {1'b0, last_idx} + (ACK_SEL+1)'(1);
        if (last_inc == REQ_LIM) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = last_inc[ACK_SEL-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (MODE == 0) begin
            ptr <= '0;
        end else if (bus.i_flush) begin
            ptr <= '0;
        end else if (bus.i_ack_rdy && ack_vld[0]) begin
            ptr <= ptr_nxt;
        end
    end

    assign bus.o_ack_vld  = ack_vld;
    assign bus.o_ack      = ack;
    assign bus.o_gnt_mask = gnt_dbl[2*REQ_NUM-1:REQ_NUM];
    assign bus.o_ptr      = ptr;
endmodule

// File: tb/tb_rr_multi_select_unit.sv
// Bench for rr_multi_select_unit: a round-robin and a fixed-priority instance share one
// stimulus stream and are compared with a scan-order model of the grant rules.
module tb_rr_multi_select_unit;
    localparam int N = 8;
    localparam int S = 3;
    localparam int G = 2;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   p_rr;
    int   p_fx;

    rr_multi_select_unit_if #(.REQ_NUM(N), .ACK_SEL(S), .GNT_NUM(G)) bus_rr ();
    rr_multi_select_unit_if #(.REQ_NUM(N), .ACK_SEL(S), .GNT_NUM(G)) bus_fx ();

    rr_multi_select_unit #(.REQ_NUM(N), .ACK_SEL(S), .GNT_NUM(G), .MODE(1)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_rr.slave)
    );
    rr_multi_select_unit #(.REQ_NUM(N), .ACK_SEL(S), .GNT_NUM(G), .MODE(0)) dut_fx (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_fx.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk indices p, p+1, ... modulo N and hand out grants in that order.
    task automatic model(input int p, input logic [N-1:0] r, output logic [G-1:0] v,
                         output logic [G*S-1:0] a, output logic [N-1:0] m, output int last);
        int n;
        int i;
        n = 0; v = '0; a = '0; m = '0; last = -1;
        for (int o = 0; o < N; o++) begin
            i = (p + o) % N;
            if (r[i] && n < G) begin
                v[n] = 1'b1;
                a[n*S +: S] = i[S-1:0];
                m[i] = 1'b1;
                last = i;
                n++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [G-1:0]   v;
        logic [G*S-1:0] a;
        logic [N-1:0]   m;
        int             last;
        model(p_rr, bus_rr.i_req, v, a, m, last);
        check({tag, ".rr.vld"},  bus_rr.o_ack_vld,  v);
        check({tag, ".rr.ack"},  bus_rr.o_ack,      a);
        check({tag, ".rr.mask"}, bus_rr.o_gnt_mask, m);
        check({tag, ".rr.ptr"},  bus_rr.o_ptr,      p_rr);
        model(p_fx, bus_fx.i_req, v, a, m, last);
        check({tag, ".fx.vld"},  bus_fx.o_ack_vld,  v);
        check({tag, ".fx.ack"},  bus_fx.o_ack,      a);
        check({tag, ".fx.mask"}, bus_fx.o_gnt_mask, m);
        check({tag, ".fx.ptr"},  bus_fx.o_ptr,      p_fx);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic rdy, input logic fl);
        bus_rr.i_req = r; bus_rr.i_ack_rdy = rdy; bus_rr.i_flush = fl;
        bus_fx.i_req = r; bus_fx.i_ack_rdy = rdy; bus_fx.i_flush = fl;
    endtask

    // Called just after a negedge: apply inputs, check, clock once, advance model.
    task automatic step(input string tag, input logic [N-1:0] r, input logic rdy, input logic fl);
        logic [G-1:0]   v;
        logic [G*S-1:0] a;
        logic [N-1:0]   m;
        int             last;
        int             nxt;
        drive(r, rdy, fl);
        #2;
        check_all(tag);
        model(p_rr, r, v, a, m, last);
        nxt = p_rr;
        if (fl) nxt = 0;
        else if (rdy && v[0]) nxt = (last + 1) % N;
        @(posedge clk);
        p_rr = nxt;
        p_fx = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] r;
        vectors = 0;
        miscompares = 0;
        p_rr = 0;
        p_fx = 0;
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);

        // Reset and empty request
        #2;
        check_all("reset");
        check("reset.ptr_const", bus_rr.o_ptr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("empty", '0, 1'b1, 1'b0);

        // Basic double grant and wrap
        drive(8'b1010_0110, 1'b1, 1'b0);
        #1;
        check("basic.ack_const",  bus_rr.o_ack, {3'd2, 3'd1});
        check("basic.mask_const", bus_rr.o_gnt_mask, 8'b0000_0110);
        step("basic0", 8'b1010_0110, 1'b1, 1'b0);
        check("basic.ptr3", bus_rr.o_ptr, 3);
        check("basic.ack57", bus_rr.o_ack, {3'd7, 3'd5});
        step("basic1", 8'b1010_0110, 1'b1, 1'b0);
        check("basic.ptr_wrap", bus_rr.o_ptr, 0);

        // Single grant, then scan wrap
        step("single", 8'b0100_0000, 1'b1, 1'b0);
        check("single.ptr7", bus_rr.o_ptr, 7);
        drive(8'b1000_0001, 1'b1, 1'b0);
        #1;
        check("wrap.ack70", bus_rr.o_ack, {3'd0, 3'd7});
        step("wrap", 8'b1000_0001, 1'b1, 1'b0);
        check("wrap.ptr1", bus_rr.o_ptr, 1);

        // Hold without handshake, then flush beats ready
        step("to3", 8'b0000_0100, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) step("hold", 8'b1100_1010, 1'b0, 1'b0);
        check("hold.ptr3", bus_rr.o_ptr, 3);
        step("flush", 8'b1100_1010, 1'b1, 1'b1);
        check("flush.ptr0", bus_rr.o_ptr, 0);

        // Fixed mode ignores handshake
        for (int c = 0; c < 4; c++) begin
            step("fixed", 8'b1010_0110, c[0], 1'b0);
            check("fixed.ack12", bus_fx.o_ack, {3'd2, 3'd1});
            check("fixed.ptr0", bus_fx.o_ptr, 0);
        end

        // Asynchronous reset between edges
        step("to5", 8'b0001_0000, 1'b1, 1'b0);
        check("to5.ptr5", bus_rr.o_ptr, 5);
        drive(8'b0010_0010, 1'b0, 1'b0);
        #1;
        check("pre_rst.ack15", bus_rr.o_ack, {3'd1, 3'd5});
        rst_n = 1'b0;
        #1;
        p_rr = 0;
        check("async_rst.ptr", bus_rr.o_ptr, 0);
        check("async_rst.ack", bus_rr.o_ack, {3'd5, 3'd1});
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 300; c++) begin
            r = N'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & N'($urandom);
            if ($urandom_range(0, 15) == 0) r = '0;
            step("rand", r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
